serial_paralelo_param: RTL and testbench
========================================

# serial_paralelo_param

Parametrised single-clock serial-to-parallel receiver for the PHY receive path, successor to the fixed 8-bit serial/parallel converter. Hunts bit-by-bit for a comma symbol in the serial stream, locks word alignment after a programmable number of consecutive aligned commas, then emits parallel words with a per-word strobe. It also flags idle (comma) words after lock. It sits behind the serialiser and feeds the receive-side word logic, all in the fast serial clock domain.

## Interface
- `WIDTH`, 8: word width in bits; legal range 2..32.
- `COMMA`, 8'hBC: alignment/idle symbol, `WIDTH` bits; must be nonzero.
- `LOCK_COUNT`, 4: consecutive aligned commas needed to lock; legal range 1..15.
- `MSB_FIRST`, 1: 1 = first serial bit is word bit `WIDTH-1`; 0 = first bit is bit 0.
- `clk_32f`  in  1  serial bit clock; one bit sampled per rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state immediately.
- `inserter`  in  1  serial data input.
- `data_out`  out  WIDTH  last received non-comma word; holds between words.
- `valid_out`  out  1  one-cycle pulse when `data_out` loads a new word.
- `IDLE_OUT`  out  1  high while the most recent word boundary held `COMMA`; active only when locked.
- `active`  out  1  alignment locked.

## Operation
- Shift register `sr` (WIDTH bits), reset 0, shifts every cycle. MSB_FIRST=1: `sr_next = {sr[WIDTH-2:0], inserter}`. MSB_FIRST=0: `sr_next = {inserter, sr[WIDTH-1:1]}`.
- All comparisons use `sr_next`, so a word is evaluated on the edge that samples its last bit.
- Bit counter `bit_cnt`, 0..WIDTH-1, wraps. Word boundary = edge where `bit_cnt == WIDTH-1`.
- Comma counter `comma_cnt` sized for `LOCK_COUNT`.
- State SEARCH (reset state):
  - Every edge: if `sr_next == COMMA`, set `bit_cnt <= 0` and `comma_cnt <= 1`.
  - Go to ACTIVE if `LOCK_COUNT == 1`, else to LOCKING.
- State LOCKING, evaluated only at word boundaries:
  - `COMMA`: increment `comma_cnt`; on reaching `LOCK_COUNT`, go to ACTIVE.
  - Anything else: go to SEARCH and clear `comma_cnt`.
  - Non-boundary edges only advance `bit_cnt`.
- State ACTIVE, evaluated at word boundaries:
  - `COMMA`: `IDLE_OUT <= 1`, `valid_out <= 0`, `data_out` holds.
  - Other word: `data_out <= sr_next`, `valid_out <= 1`, `IDLE_OUT <= 0`.
  - Non-boundary edges: `valid_out <= 0`; `IDLE_OUT` and `data_out` hold.
  - ACTIVE is left only by reset; there is no loss-of-lock detection in this generation.
- `active` = registered (state == ACTIVE).
- In SEARCH and LOCKING, `data_out`, `valid_out` and `IDLE_OUT` stay 0.

## Timing
- Reset values: `sr=0`, `bit_cnt=0`, `comma_cnt=0`, state SEARCH, `data_out=0`, `valid_out=0`, `IDLE_OUT=0`, `active=0`.
- Asserting `reset` mid-word or mid-lock clears everything asynchronously. After deassertion, alignment restarts from SEARCH with an empty `sr`; no partial word survives.
- `active` rises on the edge sampling the last bit of the LOCK_COUNT-th consecutive aligned comma.
- Word latency: `data_out`/`valid_out` update on the edge sampling the word's last bit, visible one clock after that bit was presented. `valid_out` is exactly 1 cycle wide, and there are at most 1 per WIDTH cycles.
- In SEARCH, a comma pattern straddling garbage bits still aligns: the bit-level hunt checks every edge.
- In LOCKING, a comma appearing at a non-boundary offset is ignored. Only boundary words count.
- Simultaneous events: at most one state transition per edge. The edge that enters ACTIVE does not assert `IDLE_OUT`. The first ACTIVE evaluation is the next boundary.

## Test plan
- Defaults, reset pulse, then 4×`BC` sent MSB-first -> `active` goes 1 on the 32nd bit edge after the first `BC` bit. `valid_out` stays 0 and `IDLE_OUT` stays 0 before that.
- Locked stream `BC`, `A5`, `3C`, `BC` -> `valid_out` pulses with `data_out=A5`, then `3C`, each 8 cycles apart. `IDLE_OUT` goes 1 at the second `BC` boundary and `data_out` holds `3C`.
- 3 random bits, then 4×`BC` -> lock achieved; first aligned data word `5A` reads `5A`, proving bit-level alignment.
- 3×`BC`, `00`, 4×`BC` -> the `00` returns to SEARCH with `active=0`. Lock occurs only after the later 4 commas.
- `reset` asserted for 1 cycle mid-word while ACTIVE -> all outputs 0 immediately. 4 fresh commas are needed to relock.
- `WIDTH=10`, `COMMA=10'h17C`, `MSB_FIRST=0`, `LOCK_COUNT=1` -> one `17C` sent LSB-first sets `active`. The next word `2AB` yields `data_out=2AB`.

Source files
------------

// File: rtl/serial_paralelo_param.sv
// rtl/serial_paralelo_param.sv - comma-aligned serial-to-parallel receiver
// Bit-level comma hunt, word-level lock qualification, then parallel words with strobe/idle flags.
module serial_paralelo_param #(
  parameter int               WIDTH      = 8,
  parameter logic [WIDTH-1:0] COMMA      = 8'hBC,
  parameter int               LOCK_COUNT = 4,
  parameter bit               MSB_FIRST  = 1'b1
) (
  input  logic             clk_32f,
  input  logic             reset,
  input  logic             inserter,
  output logic [WIDTH-1:0] data_out,
  output logic             valid_out,
  output logic             IDLE_OUT,
  output logic             active
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {SEARCH, LOCKING, ACTIVE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic [CW-1:0]    bit_cnt_q, bit_cnt_d;
  logic [3:0]       comma_cnt_q, comma_cnt_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             valid_q, valid_d;
  logic             idle_q, idle_d;

  logic is_comma;
  logic boundary;
  logic lock_hit;

  // Every decision looks at the word including the bit being sampled this edge.
  always_comb begin
    if (MSB_FIRST) sr_d = {sr_q[WIDTH-2:0], inserter};
    else           sr_d = {inserter, sr_q[WIDTH-1:1]};
  end

  assign is_comma = (sr_d == COMMA);
  assign boundary = (bit_cnt_q == CW'(WIDTH - 1));
  assign lock_hit = ((comma_cnt_q + 4'd1) == 4'(LOCK_COUNT));

  always_ff @(posedge clk_32f or posedge reset) begin
    if (reset) begin
      state_q     <= SEARCH;
      sr_q        <= '0;
      bit_cnt_q   <= '0;
      comma_cnt_q <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      idle_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      sr_q        <= sr_d;
      bit_cnt_q   <= bit_cnt_d;
      comma_cnt_q <= comma_cnt_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      idle_q      <= idle_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = boundary ? '0 : bit_cnt_q + CW'(1);
    comma_cnt_d = comma_cnt_q;
    case (state_q)
      SEARCH: begin
        if (is_comma) begin
          bit_cnt_d   = '0;
          comma_cnt_d = 4'd1;
          state_d     = (LOCK_COUNT == 1) ? ACTIVE : LOCKING;
        end
      end
      LOCKING: begin
        if (boundary) begin
          if (is_comma) begin
            comma_cnt_d = comma_cnt_q + 4'd1;
            if (lock_hit) state_d = ACTIVE;
          end else begin
            state_d     = SEARCH;
            comma_cnt_d = '0;
          end
        end
      end
      ACTIVE:  state_d = ACTIVE;
      default: state_d = SEARCH;
    endcase
  end

  // Word outputs only change in ACTIVE, so the locking edge itself never flags idle.
  always_comb begin
    data_d  = data_q;
    valid_d = 1'b0;
    idle_d  = idle_q;
    if (state_q == ACTIVE && boundary) begin
      if (is_comma) begin
        idle_d = 1'b1;
      end else begin
        data_d  = sr_d;
        valid_d = 1'b1;
        idle_d  = 1'b0;
      end
    end
  end

  assign data_out  = data_q;
  assign valid_out = valid_q;
  assign IDLE_OUT  = idle_q;
  assign active    = (state_q == ACTIVE);

endmodule

// File: tb/tb_serial_paralelo_param.sv
// tb/tb_serial_paralelo_param.sv - bench for serial_paralelo_param (8-bit default and 10-bit LSB-first)
module tb_serial_paralelo_param;

  logic       clk = 1'b0;
  logic       rst8, rst10, in8, in10;
  logic [7:0] d8;
  logic [9:0] d10;
  logic       v8, v10, i8, i10, a8, a10;

  int total  = 0;
  int passed = 0;

  always #5 clk = ~clk;

  serial_paralelo_param u8 (
    .clk_32f(clk), .reset(rst8), .inserter(in8),
    .data_out(d8), .valid_out(v8), .IDLE_OUT(i8), .active(a8)
  );

  serial_paralelo_param #(.WIDTH(10), .COMMA(10'h17C), .LOCK_COUNT(1), .MSB_FIRST(1'b0)) u10 (
    .clk_32f(clk), .reset(rst10), .inserter(in10),
    .data_out(d10), .valid_out(v10), .IDLE_OUT(i10), .active(a10)
  );

  int          W_ [2] = '{8, 10};
  logic [31:0] CM [2] = '{32'hBC, 32'h17C};
  int          LC [2] = '{4, 1};
  bit          MF [2] = '{1'b1, 1'b0};

  // Reference: bit history (newest in bit 0), mode 0=hunting 1=qualifying 2=locked.
  logic [63:0] hist [2];
  int          mode [2];
  int          ph   [2];
  int          cc   [2];
  logic [31:0] md   [2];
  bit          mv   [2];
  bit          mi   [2];

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  function automatic logic [31:0] window(int id);
    logic [31:0] w = '0;
    for (int k = 0; k < W_[id]; k++) begin
      if (MF[id]) w[k] = hist[id][k];
      else        w[W_[id]-1-k] = hist[id][k];
    end
    return w;
  endfunction

  task automatic model_reset(int id);
    hist[id] = '0; mode[id] = 0; ph[id] = 0; cc[id] = 0;
    md[id] = '0; mv[id] = 1'b0; mi[id] = 1'b0;
  endtask

  task automatic model_step(int id, bit b);
    logic [31:0] w;
    hist[id] = {hist[id][62:0], b};
    w = window(id);
    mv[id] = 1'b0;
    case (mode[id])
      0: if (w == CM[id]) begin
        ph[id] = 0; cc[id] = 1;
        mode[id] = (LC[id] == 1) ? 2 : 1;
      end
      1: begin
        ph[id]++;
        if (ph[id] == W_[id]) begin
          ph[id] = 0;
          if (w == CM[id]) begin
            cc[id]++;
            if (cc[id] == LC[id]) mode[id] = 2;
          end else begin
            mode[id] = 0; cc[id] = 0;
          end
        end
      end
      default: begin
        ph[id]++;
        if (ph[id] == W_[id]) begin
          ph[id] = 0;
          if (w == CM[id]) mi[id] = 1'b1;
          else begin md[id] = w; mv[id] = 1'b1; mi[id] = 1'b0; end
        end
      end
    endcase
  endtask

  task automatic check_outputs(int id);
    if (id == 0) begin
      check("data8",   32'(d8),  md[0]);
      check("valid8",  32'(v8),  32'(mv[0]));
      check("idle8",   32'(i8),  32'(mi[0]));
      check("active8", 32'(a8),  32'(mode[0] == 2));
    end else begin
      check("data10",   32'(d10), md[1]);
      check("valid10",  32'(v10), 32'(mv[1]));
      check("idle10",   32'(i10), 32'(mi[1]));
      check("active10", 32'(a10), 32'(mode[1] == 2));
    end
  endtask

  // Called at a falling edge; returns at the following falling edge.
  task automatic send_bit(int id, bit b);
    if (id == 0) in8 = b; else in10 = b;
    @(posedge clk);
    model_step(id, b);
    @(negedge clk);
    check_outputs(id);
  endtask

  task automatic send_word(int id, logic [31:0] w);
    for (int k = 0; k < W_[id]; k++)
      send_bit(id, MF[id] ? w[W_[id]-1-k] : w[k]);
  endtask

  task automatic pulse_reset(int id);
    if (id == 0) rst8 = 1'b1; else rst10 = 1'b1;
    #1;
    model_reset(id);
    check_outputs(id);
    @(negedge clk);
    if (id == 0) begin rst8 = 1'b0; in8 = 1'b0; end
    else         begin rst10 = 1'b0; in10 = 1'b0; end
  endtask

  initial begin
    rst8 = 1'b1; rst10 = 1'b1; in8 = 1'b0; in10 = 1'b0;
    model_reset(0); model_reset(1);
    @(negedge clk);
    check("reset_data8",   32'(d8), 32'h0);
    check("reset_active8", 32'(a8), 32'h0);
    @(negedge clk);
    rst8 = 1'b0;

    // Lock on four commas; active rises exactly on the 32nd bit.
    for (int n = 0; n < 3; n++) send_word(0, 32'hBC);
    for (int k = 0; k < 7; k++) send_bit(0, k inside {0, 2, 3, 4, 5});
    check("pre_lock_active", 32'(a8), 32'h0);
    send_bit(0, 1'b0);
    check("lock_active", 32'(a8), 32'h1);
    check("lock_no_idle", 32'(i8), 32'h0);

    send_word(0, 32'hBC);
    check("idle_first", 32'(i8), 32'h1);
    send_word(0, 32'hA5);
    check("word_a5", 32'(d8), 32'hA5);
    check("valid_a5", 32'(v8), 32'h1);
    send_word(0, 32'h3C);
    check("word_3c", 32'(d8), 32'h3C);
    send_word(0, 32'hBC);
    check("idle_bc", 32'(i8), 32'h1);
    check("hold_3c", 32'(d8), 32'h3C);
    check("valid_idle", 32'(v8), 32'h0);

    for (int n = 0; n < 24; n++) send_word(0, 32'($urandom_range(0, 255)));

    // Bit-level alignment behind three garbage bits.
    pulse_reset(0);
    for (int k = 0; k < 3; k++) send_bit(0, 1'($urandom_range(0, 1)));
    for (int n = 0; n < 4; n++) send_word(0, 32'hBC);
    check("garbage_lock", 32'(a8), 32'h1);
    send_word(0, 32'h5A);
    check("word_5a", 32'(d8), 32'h5A);

    // A non-comma during qualification restarts the hunt.
    pulse_reset(0);
    for (int n = 0; n < 3; n++) send_word(0, 32'hBC);
    send_word(0, 32'h00);
    check("broken_lock", 32'(a8), 32'h0);
    for (int n = 0; n < 3; n++) send_word(0, 32'hBC);
    check("relock_early", 32'(a8), 32'h0);
    send_word(0, 32'hBC);
    check("relock", 32'(a8), 32'h1);
    send_word(0, 32'hA5);

    // Mid-word reset while locked clears everything immediately.
    for (int k = 0; k < 3; k++) send_bit(0, 1'b1);
    pulse_reset(0);
    check("rst_data", 32'(d8), 32'h0);
    check("rst_active", 32'(a8), 32'h0);
    for (int n = 0; n < 3; n++) send_word(0, 32'hBC);
    check("rst_relock_early", 32'(a8), 32'h0);
    send_word(0, 32'hBC);
    check("rst_relock", 32'(a8), 32'h1);

    // 10-bit LSB-first instance, single-comma lock.
    rst8 = 1'b1;
    pulse_reset(1);
    send_word(1, 32'h17C);
    check("w10_lock", 32'(a10), 32'h1);
    send_word(1, 32'h2AB);
    check("w10_word", 32'(d10), 32'h2AB);
    check("w10_valid", 32'(v10), 32'h1);
    for (int n = 0; n < 16; n++) send_word(1, 32'($urandom_range(0, 1023)));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
